deserializer: RTL and testbench

//  Byte-to-serial transmitter: takes 8-bit parallel words from an upstream

---
 rtl/deserializer_if.sv | 36 +++
 rtl/deserializer.sv | 106 ++++++++++
 tb/tb_deserializer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deserializer_if.sv
// deserializer_if
//  Groups the byte-source handshake and the serial output of the
//  deserializer into one bundle so the block and its neighbours are wired
//  with a single connection.
//  Signals:
//    oe     - output enable from the source side (1 = transmit, 0 = idle)
//    data   - parallel byte offered by the source
//    dr     - one-cycle data request strobe back to the source
//    txclk  - forwarded serial bit clock
//    tx     - serial data, MSB first
//  Modports:
//    master - byte source / serial sink side (drives oe and data)
//    slave  - the deserializer itself (drives dr, txclk and tx)
interface deserializer_if;
  logic       oe;
  logic [7:0] data;
  logic       dr;
  logic       txclk;
  logic       tx;

  modport master (
    output oe,
    output data,
    input  dr,
    input  txclk,
    input  tx
  );

  modport slave (
    input  oe,
    input  data,
    output dr,
    output txclk,
    output tx
  );
endinterface

// File: rtl/deserializer.sv
// deserializer
//  Byte-to-serial transmitter. Takes 8-bit words from an upstream source and
//  shifts them out MSB first on tx together with a forwarded bit clock txclk.
//  Each new byte is requested with a one-cycle dr strobe timed so that the
//  next MSB directly follows the previous LSB, giving a gapless stream.
//  Parameters:
//    CLK_DIV - clk cycles per serial bit; must be even and >= 2
//  Ports:
//    clk  - system clock, all logic on its rising edge
//    rst  - synchronous active-high reset, overrides every other input
//    bus  - deserializer_if.slave: oe/data in, dr/txclk/tx out (all registered)
module deserializer #(
  parameter int CLK_DIV = 16
) (
  input  logic          clk,
  input  logic          rst,
  deserializer_if.slave bus
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN
  } state_e;

  state_e        state_q;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic [2:0]    bitCnt_q;
  // Only the seven bits still to be sent are kept: the MSB leaves on tx in
  // the same edge that captures the byte.
  logic [6:0]    shReg_q;
  logic          tx_q;
  logic          txclk_q;
  logic          dr_q;

  // Phase counter look-ahead. txclk and dr are registered, so they are
  // decoded from the phase value the counter is about to take.
  always_comb begin
    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
  end

  // Main FSM. Reset and a low oe share one path: both return to IDLE with
  // every counter and output cleared, discarding any partial byte. A dr
  // cycle always ends in a capture, whether it is the START cycle or the
  // last phase of bit 7 in RUN, which is what makes the byte seam gapless.
  always_ff @(posedge clk) begin
    if (rst || !bus.oe) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bitCnt_q <= '0;
      shReg_q  <= '0;
      tx_q     <= 1'b0;
      txclk_q  <= 1'b0;
      dr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= START;
          dr_q    <= 1'b1;
        end

        START, RUN: begin
          if (dr_q) begin
            // The source may change data on this same edge; the pre-edge
            // value is what lands here.
            state_q  <= RUN;
            shReg_q  <= bus.data[6:0];
            bitCnt_q <= '0;
            phase_q  <= '0;
            tx_q     <= bus.data[7];
            txclk_q  <= 1'b0;
            dr_q     <= 1'b0;
          end else begin
            phase_q <= phase_d;
            txclk_q <= (phase_d >= PHASE_HALF);
            // Raise dr for the final phase of bit 7 so the capture edge
            // coincides with the normal bit boundary.
            dr_q    <= (phase_d == PHASE_LAST) && (bitCnt_q == 3'd7);
            // tx only moves on the phase wrap, while txclk is low, so it is
            // stable around the txclk rising edge seen by the sink.
            if ((phase_q == PHASE_LAST) && (bitCnt_q != 3'd7)) begin
              bitCnt_q <= bitCnt_q + 3'd1;
              tx_q     <= shReg_q[6];
              shReg_q  <= {shReg_q[5:0], 1'b0};
            end
          end
        end

        default: begin
          state_q <= IDLE;
          dr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dr    = dr_q;
  assign bus.txclk = txclk_q;
  assign bus.tx    = tx_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer
//  Directed bench for the deserializer. One instance runs at CLK_DIV=16 and
//  a second at CLK_DIV=2. Bytes handed to the 16-divider instance are
//  pushed to a scoreboard queue as they are captured, and a monitor decodes
//  the bits seen on txclk rising edges back into bytes and pops them.
module tb_deserializer;

  logic clk;
  logic rst;

  deserializer_if bus16();
  deserializer_if bus2();

  deserializer #(.CLK_DIV(16)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  deserializer #(.CLK_DIV(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Free-running system clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks;
  int         failures;
  logic [7:0] sb[$];
  bit         monOn;
  int         bytesSeen;

  int         monCyc;
  int         lastRise;
  int         lastDr;
  bit         haveRise;
  bit         haveDr;
  logic       pTxclk;
  logic       pTx;
  logic       pDr;
  logic [7:0] monSh;
  int         monBits;

  // One comparison: bumps the check count and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the control inputs of both instances at the current point in time.
  task automatic applyStimulus(input logic r, input logic oe16, input logic oe2);
    rst      = r;
    bus16.oe = oe16;
    bus2.oe  = oe2;
  endtask

  // Waits, with a cycle budget, for dr of the 16-divider instance.
  task automatic waitDr16(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus16.dr) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  // Clears monitor history and the scoreboard before a monitored run.
  task automatic resetMon();
    haveRise  = 1'b0;
    haveDr    = 1'b0;
    monBits   = 0;
    monSh     = 8'h00;
    bytesSeen = 0;
    sb.delete();
  endtask

  // Monitor for the 16-divider instance, sampled on the falling clk edge.
  // Decodes bytes from txclk rising edges and checks waveform timing.
  initial begin : monitor16
    monCyc = 0;
    pTxclk = 1'b0;
    pTx    = 1'b0;
    pDr    = 1'b0;
    forever begin
      @(negedge clk);
      monCyc++;
      if (monOn) begin
        if (bus16.txclk && !pTxclk) begin
          if (haveRise) checkOutput("txclk_period", monCyc - lastRise, 16);
          haveRise = 1'b1;
          lastRise = monCyc;
          monSh    = {monSh[6:0], bus16.tx};
          monBits++;
          if (monBits == 8) begin
            monBits = 0;
            bytesSeen++;
            if (sb.size() == 0) checkOutput("sb_underflow", 32'd1, 32'd0);
            else checkOutput("byte", {24'd0, monSh}, {24'd0, sb.pop_front()});
          end
        end
        if (!bus16.txclk && pTxclk) checkOutput("txclk_high", monCyc - lastRise, 8);
        if (bus16.dr) begin
          checkOutput("dr_width", {31'd0, pDr}, 32'd0);
          if (haveDr) checkOutput("dr_period", monCyc - lastDr, 128);
          haveDr = 1'b1;
          lastDr = monCyc;
        end
        if (bus16.tx !== pTx)
          checkOutput("tx_change", {31'd0, (!bus16.txclk && (pTxclk || pDr))}, 32'd1);
      end
      pTxclk = bus16.txclk;
      pTx    = bus16.tx;
      pDr    = bus16.dr;
    end
  end

  // Directed sequence: reset, stream, byte seam, oe drop, mid-byte reset,
  // then the CLK_DIV=2 instance.
  initial begin : stimulus
    int         guard;
    int         capCount;
    int         cnt;
    logic [7:0] bits2;
    int         nb;
    int         firstRise;
    int         lastRise2;
    int         drAt;
    logic       prevClk2;
    bit         seen;

    checks     = 0;
    failures   = 0;
    monOn      = 1'b0;
    bus16.data = 8'h00;
    bus2.data  = 8'hA5;
    applyStimulus(1'b1, 1'b0, 1'b0);
    resetMon();
    repeat (3) tick();

    // Reset values on both instances.
    checkOutput("reset_outs16", {29'd0, bus16.dr, bus16.txclk, bus16.tx}, 32'd0);
    checkOutput("reset_outs2", {29'd0, bus2.dr, bus2.txclk, bus2.tx}, 32'd0);

    // Reset and oe high together: reset wins.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("rst_oe_outs", {29'd0, bus16.dr, bus16.txclk, bus16.tx}, 32'd0);

    // Counting-source stream of 100 bytes.
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    resetMon();
    monOn      = 1'b1;
    bus16.data = 8'h00;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("start_latency_dr", {31'd0, bus16.dr}, 32'd1);
    capCount = 0;
    guard    = 0;
    while (capCount < 100 && guard < 14000) begin
      if (bus16.dr) begin
        sb.push_back(bus16.data);
        capCount++;
        tick();
        bus16.data = bus16.data + 8'd1;
      end else begin
        tick();
      end
      guard++;
    end
    checkOutput("stream_captures", capCount, 100);
    waitDr16("stream_last_dr");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("stream_stop_outs", {29'd0, bus16.dr, bus16.txclk, bus16.tx}, 32'd0);
    checkOutput("stream_bytes", bytesSeen, 100);
    checkOutput("stream_sb_empty", sb.size(), 0);
    monOn = 1'b0;

    // Byte seam: 0x80 followed by 0x01.
    tick();
    resetMon();
    monOn      = 1'b1;
    bus16.data = 8'h80;
    sb.push_back(8'h80);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDr16("seam_dr0");
    tick();
    bus16.data = 8'h01;
    sb.push_back(8'h01);
    waitDr16("seam_dr1");
    tick();
    bus16.data = 8'h00;
    waitDr16("seam_dr2");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("seam_bytes", bytesSeen, 2);
    checkOutput("seam_sb_empty", sb.size(), 0);
    monOn = 1'b0;

    // oe dropped during bit 3 of 0xD3.
    tick();
    bus16.data = 8'hD3;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDr16("drop_dr0");
    tick();
    checkOutput("drop_msb", {31'd0, bus16.tx}, 32'd1);
    repeat (52) tick();
    checkOutput("drop_bit3", {31'd0, bus16.tx}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("drop_outs", {29'd0, bus16.dr, bus16.txclk, bus16.tx}, 32'd0);
    cnt = 0;
    repeat (300) begin
      tick();
      if (bus16.dr) cnt++;
    end
    checkOutput("drop_no_dr", cnt, 0);
    bus16.data = 8'hB5;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("drop_restart_dr", {31'd0, bus16.dr}, 32'd1);
    tick();
    checkOutput("drop_restart_msb", {29'd0, bus16.dr, bus16.txclk, bus16.tx}, 32'd1);
    repeat (16) tick();
    checkOutput("drop_restart_bit6", {31'd0, bus16.tx}, 32'd0);
    repeat (8) tick();
    checkOutput("drop_restart_txclk_hi", {31'd0, bus16.txclk}, 32'd1);

    // Reset in the middle of the 0xB5 byte with oe held high.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("rstmid_outs", {29'd0, bus16.dr, bus16.txclk, bus16.tx}, 32'd0);
    cnt = 0;
    repeat (10) begin
      tick();
      if ({bus16.dr, bus16.txclk, bus16.tx} != 3'b000) cnt++;
    end
    checkOutput("rstmid_hold", cnt, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rstmid_resume_dr", {31'd0, bus16.dr}, 32'd1);
    tick();
    checkOutput("rstmid_resume_msb", {31'd0, bus16.tx}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // CLK_DIV=2 instance sending 0xA5.
    applyStimulus(1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus2.dr) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("p2_dr0", {31'd0, seen}, 32'd1);
    bits2     = 8'h00;
    nb        = 0;
    firstRise = 0;
    lastRise2 = 0;
    drAt      = 0;
    prevClk2  = bus2.txclk;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus2.txclk && !prevClk2 && nb < 8) begin
        bits2 = {bits2[6:0], bus2.tx};
        if (nb == 0) firstRise = i;
        lastRise2 = i;
        nb++;
      end
      prevClk2 = bus2.txclk;
      if (bus2.dr && drAt == 0) drAt = i;
    end
    checkOutput("p2_bits", {24'd0, bits2}, 32'h0000_00A5);
    checkOutput("p2_bit_spacing", lastRise2 - firstRise, 14);
    checkOutput("p2_dr_period", drAt, 16);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
